// File: rtl/riscV_unrn_pkg.sv
// Shared definitions for the multi-cycle stage sequencer.
//   stage_e          : sequencer states; the encoding is what stage_o reports
//   STAGE_W          : width of stage_o
//   DEF_MEM_TIMEOUT  : default cycles to wait for a grant or read-valid
//   DEF_ALU_TIMEOUT  : default cycles to wait for the ALU
//   max_int          : helper used to size the wait counter
//   is_wait_state    : states in which the wait counter advances
package riscV_unrn_pkg;

    localparam int STAGE_W         = 4;
    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_ALU_TIMEOUT = 64;

    typedef enum logic [STAGE_W-1:0] {
        ST_FETCH      = 4'd0,
        ST_FETCH_WAIT = 4'd1,
        ST_DECODE     = 4'd2,
        ST_EXEC       = 4'd3,
        ST_EXEC_WAIT  = 4'd4,
        ST_MEM        = 4'd5,
        ST_MEM_WAIT   = 4'd6,
        ST_WRITEBACK  = 4'd7,
        ST_NEXT_PC    = 4'd8,
        ST_TRAP       = 4'd9
    } stage_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_wait_state(input stage_e s);
        return (s == ST_FETCH) || (s == ST_FETCH_WAIT) || (s == ST_MEM) ||
               (s == ST_MEM_WAIT) || (s == ST_EXEC_WAIT);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-cycle counter for the stage sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : restart from zero (asserted on every state change)
//   enable_i   : count this cycle
//   count_o    : cycles spent in the current wait state; saturates at all-ones
module mc_wait_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mc_stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks each instruction through
// fetch, decode, execute, memory, writeback and PC update, with a trap path
// for exceptions and for memory/ALU timeouts.
//   clk, rst_n                    : clock, synchronous active-low reset
//   mem_req_o/we_o/addr_o         : memory request; accepted by mem_gnt_i,
//                                   read data signalled by mem_rvalid_i
//   instr_latch_o                 : capture the fetched word this cycle
//   decode_o, alu_start_o         : one-cycle strobes; alu_done_i ends EXEC_WAIT
//   exc_request_i .. exc_ret_i    : decoded control flags for the instruction
//   data_addr_i, jump_dst_i       : data address and jump target
//   mtvec_i, mepc_i               : trap vector and exception return address
//   exc_present_i                 : exception detected for this instruction
//   rf_we_o, retire_o, trap_o     : one-cycle event pulses
//   pc_o, stage_o                 : current PC and state encoding
//   bus_err_o                     : last trap was a timeout; held until FETCH
//
// Handshake: a memory access completes in the cycle mem_req_o and mem_gnt_i
// are both high; a read then completes in the first later cycle with
// mem_rvalid_i high, or in the grant cycle itself if mem_rvalid_i is also high.
module mc_stage_sequencer
    import riscV_unrn_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int              MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int              ALU_TIMEOUT = DEF_ALU_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [XLEN-1:0]    mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    output logic               instr_latch_o,
    output logic               decode_o,
    output logic               alu_start_o,
    input  logic               alu_done_i,
    input  logic               exc_request_i,
    input  logic               reg_write_i,
    input  logic               mem_access_i,
    input  logic               mem_write_i,
    input  logic               jump_i,
    input  logic               exc_ret_i,
    input  logic [XLEN-1:0]    data_addr_i,
    input  logic [XLEN-1:0]    jump_dst_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    input  logic               exc_present_i,
    output logic               rf_we_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic               retire_o,
    output logic               trap_o,
    output logic               bus_err_o
);

    localparam int              CNT_W     = $clog2(max_int(MEM_TIMEOUT, ALU_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] MEM_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] ALU_LIMIT = CNT_W'(ALU_TIMEOUT);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]  HALF_MASK = ~XLEN'(1);

    stage_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            bus_err_q, bus_err_d;
    logic [CNT_W-1:0] wait_cnt;

    logic            req_c, we_c, latch_c, decode_c, alu_start_c;
    logic            rf_we_c, retire_c, trap_c, timeout_c;
    logic [XLEN-1:0] addr_c;
    logic            mem_tmo, alu_tmo;

    assign mem_tmo = (wait_cnt == MEM_LIMIT);
    assign alu_tmo = (wait_cnt == ALU_LIMIT);

    mc_wait_timer #(
        .W(CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_d != state_q),
        .enable_i (is_wait_state(state_q)),
        .count_o  (wait_cnt)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        bus_err_d   = bus_err_q;
        req_c       = 1'b0;
        we_c        = 1'b0;
        addr_c      = pc_q;
        latch_c     = 1'b0;
        decode_c    = 1'b0;
        alu_start_c = 1'b0;
        rf_we_c     = 1'b0;
        retire_c    = 1'b0;
        trap_c      = 1'b0;
        timeout_c   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                req_c = 1'b1;
                if (mem_gnt_i) begin
                    // Grant and data together: fetch completes now.
                    if (mem_rvalid_i) begin
                        latch_c = 1'b1;
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_FETCH_WAIT;
                    end
                end else if (mem_tmo) begin
                    timeout_c = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_FETCH_WAIT: begin
                if (mem_rvalid_i) begin
                    latch_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (mem_tmo) begin
                    timeout_c = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_DECODE: begin
                decode_c = 1'b1;
                state_d  = exc_request_i ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                alu_start_c = 1'b1;
                state_d     = ST_EXEC_WAIT;
            end

            ST_EXEC_WAIT: begin
                if (alu_done_i) begin
                    if (mem_access_i) begin
                        state_d = ST_MEM;
                    end else if (reg_write_i) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_NEXT_PC;
                    end
                end else if (alu_tmo) begin
                    timeout_c = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_MEM: begin
                // A faulting data access never reaches the bus.
                if (exc_present_i) begin
                    state_d = ST_TRAP;
                end else begin
                    req_c  = 1'b1;
                    we_c   = mem_write_i;
                    addr_c = data_addr_i;
                    if (mem_gnt_i) begin
                        if (mem_write_i) begin
                            state_d = ST_NEXT_PC;
                        end else if (mem_rvalid_i) begin
                            state_d = ST_WRITEBACK;
                        end else begin
                            state_d = ST_MEM_WAIT;
                        end
                    end else if (mem_tmo) begin
                        timeout_c = 1'b1;
                        state_d   = ST_TRAP;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_WRITEBACK;
                end else if (mem_tmo) begin
                    timeout_c = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_WRITEBACK: begin
                rf_we_c = reg_write_i & ~exc_present_i;
                state_d = ST_NEXT_PC;
            end

            ST_NEXT_PC: begin
                if (exc_present_i && jump_i) begin
                    state_d = ST_TRAP;
                end else begin
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                    if (exc_ret_i) begin
                        pc_d = mepc_i;
                    end else if (jump_i) begin
                        pc_d = jump_dst_i & HALF_MASK;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end

            ST_TRAP: begin
                trap_c  = 1'b1;
                pc_d    = mtvec_i;
                state_d = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (timeout_c) begin
            bus_err_d = 1'b1;
        end else if (state_d == ST_FETCH) begin
            bus_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Pulses and requests are suppressed while reset is held so an access
    // interrupted by reset produces no side effects.
    assign mem_req_o     = req_c & rst_n;
    assign mem_we_o      = we_c & rst_n;
    assign mem_addr_o    = addr_c;
    assign instr_latch_o = latch_c & rst_n;
    assign decode_o      = decode_c & rst_n;
    assign alu_start_o   = alu_start_c & rst_n;
    assign rf_we_o       = rf_we_c & rst_n;
    assign retire_o      = retire_c & rst_n;
    assign trap_o        = trap_c & rst_n;
    assign bus_err_o     = bus_err_q;
    assign pc_o          = pc_q;
    assign stage_o       = state_q;

endmodule

// File: doc/mc_stage_sequencer.md
MC_STAGE_SEQUENCER -- requirements
Module: mc_stage_sequencer

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath/PC width; RESET_PC, default 32'h8000_0000, PC after reset; MEM_TIMEOUT, default 16, maximum wait cycles for a grant or read-valid; ALU_TIMEOUT, default 64, maximum cycles to wait for alu_done_i.
REQ-002 Ports SHALL be: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-003 Ports SHALL be: mem_req_o  out  1  request; mem_we_o  out  1  write request; mem_addr_o  out  XLEN  address; mem_gnt_i  in  1  request accepted; mem_rvalid_i  in  1  read data valid.
REQ-004 Ports SHALL be: instr_latch_o  out  1  capture fetched word; decode_o  out  1  one-cycle decode strobe; alu_start_o  out  1  ALU start pulse; alu_done_i  in  1  ALU result valid.
REQ-005 Ports SHALL be: exc_request_i, reg_write_i, mem_access_i, mem_write_i, jump_i, exc_ret_i  in  1 each  decoded control flags; data_addr_i, jump_dst_i, mtvec_i, mepc_i  in  XLEN each.
REQ-006 Ports SHALL be: exc_present_i  in  1  detected exception; rf_we_o  out  1  register write; pc_o  out  XLEN  current PC; stage_o  out  4  current state; retire_o  out  1  instruction retired; trap_o  out  1  entering trap; bus_err_o  out  1  timeout cause valid.

Function
REQ-007 States SHALL be FETCH, FETCH_WAIT, DECODE, EXEC, EXEC_WAIT, MEM, MEM_WAIT, WRITEBACK, NEXT_PC, TRAP, with stage_o reflecting the encoding.
REQ-008 FETCH SHALL drive mem_req_o=1, mem_we_o=0, mem_addr_o=pc_o, holding until mem_gnt_i, then go to FETCH_WAIT.
REQ-009 FETCH_WAIT SHALL pulse instr_latch_o in the mem_rvalid_i cycle and go to DECODE next.
REQ-010 DECODE SHALL pulse decode_o for exactly one cycle, then go to TRAP if exc_request_i, otherwise EXEC.
REQ-011 EXEC SHALL pulse alu_start_o for one cycle and go to EXEC_WAIT; EXEC_WAIT SHALL go to MEM on alu_done_i if mem_access_i, otherwise to WRITEBACK if reg_write_i, otherwise to NEXT_PC.
REQ-012 MEM SHALL go to TRAP if exc_present_i and SHALL issue no request in that case; otherwise it SHALL drive mem_req_o=1, mem_addr_o=data_addr_i, mem_we_o=mem_write_i until grant.
REQ-013 On grant, a store SHALL go to NEXT_PC; a load SHALL go to MEM_WAIT and then to WRITEBACK on mem_rvalid_i.
REQ-014 WRITEBACK SHALL assert rf_we_o=reg_write_i & ~exc_present_i for exactly one cycle, then go to NEXT_PC.
REQ-015 NEXT_PC priority SHALL be: exc_present_i&jump_i -> TRAP; exc_ret_i -> pc=mepc_i; jump_i -> pc={jump_dst_i[XLEN-1:1],1'b0}; else pc=pc+4 modulo 2^XLEN (wraps at all-ones).
REQ-016 In NEXT_PC, retire_o SHALL pulse one cycle on non-trap paths, and the next state SHALL be FETCH.
REQ-017 TRAP SHALL load pc=mtvec_i, pulse trap_o for one cycle, not pulse retire_o, and go to FETCH.
REQ-018 A wait counter SHALL clear on every state change and increment while in FETCH, FETCH_WAIT, MEM, MEM_WAIT or EXEC_WAIT.
REQ-019 When the counter reaches MEM_TIMEOUT in a memory state, or ALU_TIMEOUT in EXEC_WAIT, the block SHALL go to TRAP and hold bus_err_o high until the next FETCH.
REQ-020 If mem_gnt_i and mem_rvalid_i arrive in the same cycle in FETCH or MEM, the block SHALL treat the access as complete and skip the corresponding WAIT state.
REQ-021 pc_o SHALL change only on the NEXT_PC->FETCH or TRAP->FETCH transition.

Reset
REQ-022 With rst_n low at a clock edge: state=FETCH, pc_o=RESET_PC, counter=0, bus_err_o=0, and all pulse and request outputs=0 from the next cycle.
REQ-023 Reset asserted mid-access SHALL abandon the access with no retire, trap or rf_we pulse.

Structure
REQ-024 The state enum, the stage_o width, and the timeout defaults SHALL live in riscV_unrn_pkg.
REQ-025 The wait counter SHALL be a sub-module, mc_wait_timer, with parametrised width $clog2(max(MEM_TIMEOUT,ALU_TIMEOUT)+1).

Verification
REQ-026 Zero-wait memory (gnt and rvalid in the same cycle), ALU done in 1 cycle, ADD -> retire after 6 cycles, pc 8000_0000 -> 8000_0004.
REQ-027 Load with grant delayed 3 cycles and rvalid delayed 2 more -> one rf_we pulse, retire, correct stage sequence.
REQ-028 jump_i with jump_dst_i=8000_0103 -> pc=8000_0102; exc_ret_i with mepc_i=8000_0040 -> pc=8000_0040.
REQ-029 mem_gnt_i held low with MEM_TIMEOUT=16 -> TRAP on counter 16, bus_err_o=1, pc=mtvec_i, no retire.
REQ-030 pc=FFFF_FFFC with sequential flow -> pc=0000_0000; rst_n low during MEM_WAIT -> FETCH at RESET_PC with no pulses.
